memio_responder: RTL and testbench

- Responder end of the CPU data-memory/IO interface.
- Takes one load/store request at a time from the multicycle control/datapath during its memory state. The request carries MemRead/MemWrite/IORead/IOWrite, Memory_sign and Memory_data_width, already decoded from Alu_resultHigh.
- Executes the access on a 1-cycle-latency synchronous data RAM (byte-write enables) or on the req/ack IO bus.
- Returns aligned, sign/zero-extended load data with a done pulse; the control FSM holds its memory state until that pulse.

---
 rtl/memio_pkg.sv | 17 +
 rtl/memio_lane_align.sv | 52 +++++
 rtl/memio_responder.sv | 169 ++++++++++++++++
 tb/tb_memio_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/memio_pkg.sv
// Shared encodings for the CPU data-memory/IO responder.
package memio_pkg;

  localparam logic [1:0]  W_BYTE       = 2'b00;
  localparam logic [1:0]  W_HALF       = 2'b01;
  localparam logic [1:0]  W_WORD       = 2'b11;
  localparam logic [21:0] IO_PAGE_HIGH = 22'h3FFFFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAM_ACC  = 3'd1,
    S_RAM_CAPT = 3'd2,
    S_IO_WAIT  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/memio_lane_align.sv
// Little-endian lane steering: byte enables, store replication, load extract/extend.
module memio_lane_align
  import memio_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_width,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_we    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = 32'h0;
    case (i_width)
      W_BYTE: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
      end
      W_HALF: begin
        o_we    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sign & w_half[15]}}, w_half};
      end
      W_WORD: begin
        o_we    = 4'b1111;
        o_rdata = i_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memio_responder.sv
// Responder for the CPU memory state: one load/store at a time to sync RAM or req/ack IO bus.
module memio_responder
  import memio_pkg::*;
#(
  parameter int RAM_AW     = 14,
  parameter int IO_AW      = 10,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IORead,
  input  logic              IOWrite,
  input  logic              Memory_sign,
  input  logic [1:0]        Memory_data_width,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              req_ready,
  output logic [31:0]       rdata,
  output logic              addr_error,
  output logic              bus_error,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  localparam int CW = $clog2(IO_TIMEOUT + 1);

  state_t        r_state;
  logic [1:0]    r_addr_lo;
  logic [1:0]    r_width;
  logic          r_sign;
  logic          r_load;
  logic [CW-1:0] r_cnt;

  logic [3:0]  w_strb;
  logic        w_any;
  logic        w_multi;
  logic        w_misalign;
  logic [1:0]  w_al_addr;
  logic [1:0]  w_al_width;
  logic        w_al_sign;
  logic [31:0] w_al_rsrc;
  logic [3:0]  w_we;
  logic [31:0] w_wrep;
  logic [31:0] w_rext;

  assign w_strb     = {MemRead, MemWrite, IORead, IOWrite};
  assign w_any      = |w_strb;
  assign w_multi    = (w_strb & (w_strb - 4'd1)) != 4'd0;
  assign w_misalign = (Memory_data_width == 2'b10) ||
                      (Memory_data_width == W_HALF && addr[0]) ||
                      (Memory_data_width == W_WORD && addr[1:0] != 2'b00);

  // Aligner sees live request fields at accept (store steering) and latched ones afterwards.
  assign w_al_addr  = (r_state == S_IDLE) ? addr[1:0] : r_addr_lo;
  assign w_al_width = (r_state == S_IDLE) ? Memory_data_width : r_width;
  assign w_al_sign  = (r_state == S_IDLE) ? Memory_sign : r_sign;
  assign w_al_rsrc  = (r_state == S_IO_WAIT) ? io_rdata : ram_rdata;

  memio_lane_align u_align (
    .i_addr_lo (w_al_addr),
    .i_width   (w_al_width),
    .i_sign    (w_al_sign),
    .i_wdata   (wdata),
    .i_rdata   (w_al_rsrc),
    .o_we      (w_we),
    .o_wdata   (w_wrep),
    .o_rdata   (w_rext)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr_lo  <= '0;
      r_width    <= '0;
      r_sign     <= 1'b0;
      r_load     <= 1'b0;
      r_cnt      <= '0;
      req_ready  <= 1'b0;
      rdata      <= '0;
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      io_req     <= 1'b0;
      io_we      <= 1'b0;
      io_addr    <= '0;
      io_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid && w_any) begin
          r_addr_lo <= addr[1:0];
          r_width   <= Memory_data_width;
          r_sign    <= Memory_sign;
          r_load    <= MemRead | IORead;
          if (w_multi || w_misalign) begin
            r_state    <= S_DONE;
            req_ready  <= 1'b1;
            addr_error <= 1'b1;
            rdata      <= '0;
          end else if (MemRead || MemWrite) begin
            r_state   <= S_RAM_ACC;
            ram_en    <= 1'b1;
            ram_we    <= MemWrite ? w_we : 4'b0000;
            ram_addr  <= addr[RAM_AW+1:2];
            ram_wdata <= w_wrep;
          end else begin
            r_state  <= S_IO_WAIT;
            io_req   <= 1'b1;
            io_we    <= IOWrite;
            io_addr  <= addr[IO_AW-1:0];
            io_wdata <= w_wrep;
            r_cnt    <= '0;
          end
        end
        S_RAM_ACC: begin
          ram_en <= 1'b0;
          ram_we <= 4'b0000;
          if (r_load) r_state <= S_RAM_CAPT;
          else begin
            r_state   <= S_DONE;
            req_ready <= 1'b1;
          end
        end
        S_RAM_CAPT: begin
          rdata     <= w_rext;
          req_ready <= 1'b1;
          r_state   <= S_DONE;
        end
        S_IO_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (io_ack) begin
            io_req    <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_DONE;
            if (r_load) rdata <= w_rext;
          end else if (r_cnt == CW'(IO_TIMEOUT - 1)) begin
            io_req    <= 1'b0;
            rdata     <= '0;
            bus_error <= 1'b1;
            req_ready <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          req_ready  <= 1'b0;
          addr_error <= 1'b0;
          bus_error  <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memio_responder.sv
// Directed-vector bench for memio_responder with hand-computed expectations.
module tb_memio_responder;
  import memio_pkg::*;

  localparam int RAM_AW = 14;
  localparam int IO_AW  = 10;
  localparam int IO_TO  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              MemRead = 1'b0, MemWrite = 1'b0, IORead = 1'b0, IOWrite = 1'b0;
  logic              Memory_sign = 1'b0;
  logic [1:0]        Memory_data_width = 2'b00;
  logic [31:0]       addr = '0, wdata = '0;
  logic              req_ready, addr_error, bus_error;
  logic [31:0]       rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic              io_req, io_we;
  logic [IO_AW-1:0]  io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata = '0;
  logic              io_ack = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  memio_responder #(.RAM_AW(RAM_AW), .IO_AW(IO_AW), .IO_TIMEOUT(IO_TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite),
    .Memory_sign(Memory_sign), .Memory_data_width(Memory_data_width),
    .addr(addr), .wdata(wdata), .req_ready(req_ready), .rdata(rdata),
    .addr_error(addr_error), .bus_error(bus_error),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle after the accept edge (T+1).
  task automatic issue(input logic [3:0] strb, input logic sgn, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    {MemRead, MemWrite, IORead, IOWrite} = strb;
    Memory_sign = sgn; Memory_data_width = w; addr = a; wdata = d;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    {MemRead, MemWrite, IORead, IOWrite} = 4'b0000;
  endtask

  initial begin
    int n;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_en_we", {27'd0, ram_en, ram_we}, 32'd0);
    chk("rst_io_req", 32'(io_req), 32'd0);
    chk("rst_err", {30'd0, addr_error, bus_error}, 32'd0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // sw 0x10
    issue(4'b0100, 1'b0, W_WORD, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("sw_ram_en", 32'(ram_en), 32'd1);
    chk("sw_ram_we", 32'(ram_we), 32'hF);
    chk("sw_ram_addr", 32'(ram_addr), 32'd4);
    chk("sw_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("sw_ready_t1", 32'(req_ready), 32'd0);
    cyc();
    chk("sw_ready_t2", 32'(req_ready), 32'd1);
    chk("sw_ram_en_t2", 32'(ram_en), 32'd0);
    cyc();
    chk("sw_ready_drop", 32'(req_ready), 32'd0);

    // lb / lbu at 0x13
    ram_rdata = 32'h8000_0000;
    issue(4'b1000, 1'b1, W_BYTE, 32'h0000_0013, 32'h0);
    chk("lb_ram_en", 32'(ram_en), 32'd1);
    chk("lb_ram_we", 32'(ram_we), 32'h0);
    chk("lb_ram_addr", 32'(ram_addr), 32'd4);
    cyc();
    chk("lb_ready_t2", 32'(req_ready), 32'd0);
    cyc();
    chk("lb_ready_t3", 32'(req_ready), 32'd1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    cyc();
    issue(4'b1000, 1'b0, W_BYTE, 32'h0000_0013, 32'h0);
    cyc(); cyc();
    chk("lbu_ready", 32'(req_ready), 32'd1);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    cyc();

    // sh at 0x06
    issue(4'b0100, 1'b0, W_HALF, 32'h0000_0006, 32'h0000_1234);
    chk("sh_ram_we", 32'(ram_we), 32'hC);
    chk("sh_ram_wdata", ram_wdata, 32'h1234_1234);
    chk("sh_ram_addr", 32'(ram_addr), 32'd1);
    cyc();
    chk("sh_ready", 32'(req_ready), 32'd1);
    chk("sh_rdata_kept", rdata, 32'h0000_0080);
    cyc();

    // misaligned lw at 0x02
    issue(4'b1000, 1'b1, W_WORD, 32'h0000_0002, 32'h0);
    chk("lw_mis_ready", 32'(req_ready), 32'd1);
    chk("lw_mis_aerr", 32'(addr_error), 32'd1);
    chk("lw_mis_rdata", rdata, 32'd0);
    chk("lw_mis_no_acc", {30'd0, ram_en, io_req}, 32'd0);
    cyc();
    chk("lw_mis_after", {29'd0, ram_en, io_req, addr_error}, 32'd0);

    // zero strobes ignored
    issue(4'b0000, 1'b0, W_WORD, 32'h0000_0010, 32'h0);
    chk("nostrb_idle", {29'd0, req_ready, ram_en, io_req}, 32'd0);

    // multiple strobes and reserved width
    issue(4'b1010, 1'b0, W_BYTE, 32'h0000_0000, 32'h0);
    chk("multi_aerr", {30'd0, req_ready, addr_error}, 32'h3);
    cyc();
    issue(4'b1000, 1'b0, 2'b10, 32'h0000_0000, 32'h0);
    chk("resw_aerr", {30'd0, req_ready, addr_error}, 32'h3);
    cyc();

    // IO lhu at page 0x060, ack in the fifth wait cycle
    io_rdata = 32'h0000_00A5;
    issue(4'b0010, 1'b0, W_HALF, {IO_PAGE_HIGH, 10'h060}, 32'h0);
    chk("io_rd_req", {30'd0, io_req, io_we}, 32'h2);
    chk("io_rd_addr", 32'(io_addr), 32'h060);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("io_rd_req_hold", {30'd0, io_req, req_ready}, 32'h2);
    end
    io_ack = 1'b1;
    cyc();
    io_ack = 1'b0;
    chk("io_rd_ready", 32'(req_ready), 32'd1);
    chk("io_rd_req_drop", 32'(io_req), 32'd0);
    chk("io_rd_rdata", rdata, 32'h0000_00A5);
    chk("io_rd_berr", 32'(bus_error), 32'd0);
    io_ack = 1'b1;
    cyc();
    io_ack = 1'b0;
    chk("stray_ack", {30'd0, req_ready, io_req}, 32'd0);

    // IO sb with no ack -> timeout
    issue(4'b0001, 1'b0, W_BYTE, {IO_PAGE_HIGH, 10'h004}, 32'h0000_0055);
    chk("io_wr_we", 32'(io_we), 32'd1);
    chk("io_wr_wdata", io_wdata, 32'h5555_5555);
    n = 0;
    while (io_req && n < 20) begin
      n++;
      cyc();
    end
    chk("io_to_cycles", 32'(n), 32'(IO_TO));
    chk("io_to_ready", {30'd0, req_ready, bus_error}, 32'h3);
    chk("io_to_rdata", rdata, 32'd0);
    cyc();
    chk("io_to_after", {30'd0, req_ready, bus_error}, 32'd0);

    // reset mid IO wait
    issue(4'b0010, 1'b0, W_WORD, {IO_PAGE_HIGH, 10'h010}, 32'h0);
    cyc();
    chk("mid_io_req", 32'(io_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_io_req", 32'(io_req), 32'd0);
    #1;
    reset = 1'b1;
    cyc();

    // lw then lh after reset
    ram_rdata = 32'h8001_5678;
    issue(4'b1000, 1'b0, W_WORD, 32'h0000_0020, 32'h0);
    chk("post_lw_addr", 32'(ram_addr), 32'd8);
    cyc(); cyc();
    chk("post_lw_ready", 32'(req_ready), 32'd1);
    chk("post_lw_rdata", rdata, 32'h8001_5678);
    cyc();
    issue(4'b1000, 1'b1, W_HALF, 32'h0000_0022, 32'h0);
    cyc(); cyc();
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
